// File: rtl/tech_rff_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tech_rff_defs (package)
//  Brief    : Shared defaults, count-update encoding and the occupancy-count
//             width helper for the tech_rff elastic register pipeline.
//  Revision : 1.0 - initial release
// ============================================================================
package tech_rff_defs;

  // Default geometry of the pipeline.
  localparam int unsigned TECH_RFF_DEF_WIDTH     = 8;
  localparam int unsigned TECH_RFF_DEF_DEPTH     = 4;
  // Default value loaded into every data register on reset.
  localparam int unsigned TECH_RFF_DEF_RESET_VAL = 0;

  // Per-cycle update applied to the occupancy counter.
  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_op_e;

  // Width needed to hold 0..depth. An illegal depth of 0 still yields a
  // legal width so the elaboration-time depth check is the one that fires.
  function automatic int unsigned tech_rff_cw(input int unsigned depth);
    if (depth < 1) begin
      return 1;
    end
    return $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tech_rff_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tech_rff_stage
//  Brief    : One elastic register stage: a valid flop and an enable-gated
//             data flop. The stage is ready when it is empty or when the
//             stage downstream of it is ready, so bubbles collapse.
//  Revision : 1.0 - initial release
// ============================================================================
module tech_rff_stage #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             dn_ready,
  output logic             up_ready,
  output logic             v,
  output logic [WIDTH-1:0] d
);

  logic             v_q;
  logic             v_d;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] d_d;

  // An empty stage can always take a word; a full one only if its word moves on.
  assign up_ready = ~v_q | dn_ready;

  // Next state: load from upstream when ready; data only moves with a valid word.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (up_ready) begin
      v_d = up_valid;
      if (up_valid) begin
        d_d = up_data;
      end
    end
  end

  // State register: reset clears valid and data, flush clears valid only.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= 1'b0;
      d_q <= RESET_VAL;
    end else if (flush) begin
      v_q <= 1'b0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign v = v_q;
  assign d = d_q;

endmodule
`default_nettype wire

// File: rtl/tech_rff_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tech_rff_pipe
//  Brief    : Parametrised elastic register pipeline of DEPTH stages with
//             valid/ready flow control, programmable reset value, synchronous
//             flush and a registered occupancy count.
//  Revision : 1.0 - initial release
// ============================================================================
module tech_rff_pipe
  import tech_rff_defs::*;
#(
  parameter  int unsigned      WIDTH     = TECH_RFF_DEF_WIDTH,
  parameter  int unsigned      DEPTH     = TECH_RFF_DEF_DEPTH,
  parameter  logic [WIDTH-1:0] RESET_VAL = WIDTH'(TECH_RFF_DEF_RESET_VAL),
  localparam int unsigned      CW        = tech_rff_cw(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    count
);

  if (DEPTH < 1) begin : g_bad_depth
    $error("tech_rff_pipe: DEPTH must be at least 1");
  end

  logic          w_accept;
  logic          w_emit;
  logic          w_last_valid;
  logic          w_first_ready;
  cnt_op_e       w_cnt_op;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Stage chain. Each stage owns its own ready/valid/data nets so the
  // combinational ready chain never feeds back through a shared vector.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             w_up_ready;
    logic             w_dn_ready;
    logic             w_up_valid;
    logic [WIDTH-1:0] w_up_data;
    logic             w_v;
    logic [WIDTH-1:0] w_d;

    if (i == 0) begin : g_first
      assign w_up_valid = in_valid;
      assign w_up_data  = in_data;
    end else begin : g_inner_up
      assign w_up_valid = g_stage[i-1].w_v;
      assign w_up_data  = g_stage[i-1].w_d;
    end

    if (i == DEPTH - 1) begin : g_last
      assign w_dn_ready = out_ready;
    end else begin : g_inner_dn
      assign w_dn_ready = g_stage[i+1].w_up_ready;
    end

    tech_rff_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .up_valid (w_up_valid),
      .up_data  (w_up_data),
      .dn_ready (w_dn_ready),
      .up_ready (w_up_ready),
      .v        (w_v),
      .d        (w_d)
    );
  end

  assign w_first_ready = g_stage[0].w_up_ready;
  assign w_last_valid  = g_stage[DEPTH-1].w_v;

  // Neither side may transfer while the pipe is being reset or flushed.
  assign in_ready  = w_first_ready & ~flush & ~reset;
  assign out_valid = w_last_valid & ~flush;
  assign out_data  = g_stage[DEPTH-1].w_d;

  assign w_accept = in_valid & in_ready;
  assign w_emit   = out_valid & out_ready & ~reset;

  // Occupancy update: a simultaneous accept and emit leaves the count alone.
  always_comb begin
    w_cnt_op = CNT_HOLD;
    count_d  = count_q;
    if (w_accept && !w_emit) begin
      w_cnt_op = CNT_INC;
    end else if (w_emit && !w_accept) begin
      w_cnt_op = CNT_DEC;
    end
    case (w_cnt_op)
      CNT_INC: count_d = count_q + CW'(1);
      CNT_DEC: count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Occupancy register: reset and flush both empty the pipe.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (flush) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire
